// File: rtl/imem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory: FSM state encoding,
// the MIPS NOP word and a word-index width helper.
package imem_loadable_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_LOAD = ST_LOAD,
      S_RUN  = ST_RUN
   } state_e;

   // sll $0,$0,0 encodes as all zeros
   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

   function automatic int word_idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/imem_word_ram.sv
// Word RAM with one synchronous write port and one registered read port.
// Contents and read register are deliberately left unreset.
module imem_word_ram
   import imem_loadable_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = word_idx_w(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with a big-endian byte-stream boot loader and a
// one-cycle registered fetch port that reports misaligned/out-of-range faults.
module imem_loadable
   import imem_loadable_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter int          ADDR_W      = 32,
   parameter logic [31:0] NOP_WORD    = MIPS_NOP
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load_start,
   input  logic [7:0]                     load_byte,
   input  logic                           load_valid,
   input  logic                           load_last,
   output logic                           load_ready,
   output logic                           load_done,
   output logic                           load_err,
   output logic [$clog2(DEPTH_WORDS):0]   load_words,
   input  logic                           fetch_req,
   input  logic [ADDR_W-1:0]              fetch_addr,
   output logic                           fetch_ready,
   output logic                           fetch_valid,
   output logic [31:0]                    fetch_data,
   output logic                           fetch_fault
);

   localparam int WI = word_idx_w(DEPTH_WORDS);
   localparam int CW = WI + 1;
   localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH_WORDS);
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH_WORDS);

   state_e        state_q, state_d;
   logic [1:0]    byte_cnt_q, byte_cnt_d;
   logic [CW-1:0] word_ptr_q, word_ptr_d;
   logic [31:0]   asm_q, asm_d;
   logic          load_err_q, load_err_d;
   logic          load_done_q, load_done_d;
   logic          load_ready_q, load_ready_d;
   logic          fetch_ready_q, fetch_ready_d;
   logic          fetch_valid_q, fetch_valid_d;
   logic          fetch_fault_q, fetch_fault_d;
   logic          fetch_hit_q, fetch_hit_d;

   logic              byte_hs;
   logic              overflow;
   logic [31:0]       byte_word;
   logic              wr_en;
   logic [31:0]       wr_data;
   logic              fetch_acc;
   logic              fetch_bad;
   logic [ADDR_W-1:0] fetch_word_idx;
   logic              rd_en;
   logic [31:0]       ram_rd_data;

   // load_start wins over a same-cycle byte, which is then left unconsumed
   assign byte_hs   = load_valid & load_ready_q & ~load_start;
   assign overflow  = (word_ptr_q == DEPTH_C) && (byte_cnt_q == 2'd0);
   assign byte_word = {load_byte, 24'h000000} >> {byte_cnt_q, 3'b000};
   assign wr_data   = asm_q | byte_word;

   assign fetch_acc      = fetch_req & fetch_ready_q;
   assign fetch_word_idx = fetch_addr >> 2;
   assign fetch_bad      = (fetch_addr[1:0] != 2'b00) || (fetch_word_idx >= DEPTH_A);
   assign rd_en          = fetch_acc & ~fetch_bad;

   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      word_ptr_d    = word_ptr_q;
      asm_d         = asm_q;
      load_err_d    = load_err_q;
      load_done_d   = 1'b0;
      wr_en         = 1'b0;

      if (load_start) begin
         state_d    = S_LOAD;
         byte_cnt_d = 2'd0;
         word_ptr_d = '0;
         asm_d      = '0;
         load_err_d = 1'b0;
      end else if (byte_hs) begin
         // A last byte on a partial word flushes it with zero padding
         if (overflow) begin
            load_err_d = 1'b1;
         end else if ((byte_cnt_q == 2'd3) || load_last) begin
            wr_en      = 1'b1;
            word_ptr_d = word_ptr_q + CW'(1);
            byte_cnt_d = 2'd0;
            asm_d      = '0;
         end else begin
            asm_d      = wr_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
         end
         if (load_last) begin
            state_d     = S_RUN;
            load_done_d = 1'b1;
         end
      end

      load_ready_d  = (state_d == S_LOAD);
      fetch_ready_d = (state_d == S_RUN);

      fetch_valid_d = fetch_acc;
      fetch_fault_d = fetch_acc & fetch_bad;
      fetch_hit_d   = fetch_acc ? ~fetch_bad : fetch_hit_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         byte_cnt_q    <= 2'd0;
         word_ptr_q    <= '0;
         asm_q         <= '0;
         load_err_q    <= 1'b0;
         load_done_q   <= 1'b0;
         load_ready_q  <= 1'b0;
         fetch_ready_q <= 1'b0;
         fetch_valid_q <= 1'b0;
         fetch_fault_q <= 1'b0;
         fetch_hit_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         word_ptr_q    <= word_ptr_d;
         asm_q         <= asm_d;
         load_err_q    <= load_err_d;
         load_done_q   <= load_done_d;
         load_ready_q  <= load_ready_d;
         fetch_ready_q <= fetch_ready_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_fault_q <= fetch_fault_d;
         fetch_hit_q   <= fetch_hit_d;
      end
   end

   imem_word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (WI)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (word_ptr_q[WI-1:0]),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (fetch_addr[WI+1:2]),
      .rd_data (ram_rd_data)
   );

   // Faulting fetches and the post-reset value both present the NOP word
   assign fetch_data  = fetch_hit_q ? ram_rd_data : NOP_WORD;
   assign fetch_valid = fetch_valid_q;
   assign fetch_fault = fetch_fault_q;
   assign fetch_ready = fetch_ready_q;
   assign load_ready  = load_ready_q;
   assign load_done   = load_done_q;
   assign load_err    = load_err_q;
   assign load_words  = word_ptr_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: directed loader/fetch sequences,
// a fetch vector table and randomized loads checked against a word-level model.
module tb_imem_loadable;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic [7:0]    load_byte;
   logic          load_valid;
   logic          load_last;
   logic          load_ready;
   logic          load_done;
   logic          load_err;
   logic [LW-1:0] load_words;
   logic          fetch_req;
   logic [31:0]   fetch_addr;
   logic          fetch_ready;
   logic          fetch_valid;
   logic [31:0]   fetch_data;
   logic          fetch_fault;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  lb [64];
   logic [31:0] model_mem [DEPTH];
   bit          known [DEPTH];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] exp_data;
      logic        exp_fault;
   } fetch_vec_t;

   fetch_vec_t vecs [8];

   imem_loadable #(
      .DEPTH_WORDS (DEPTH),
      .ADDR_W      (32),
      .NOP_WORD    (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .load_byte   (load_byte),
      .load_valid  (load_valid),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .load_done   (load_done),
      .load_err    (load_err),
      .load_words  (load_words),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic [31:0] addr);
      fetch_req  = req;
      fetch_addr = addr;
      step();
   endtask

   function automatic logic expFault(input logic [31:0] a);
      return ((a % 4) != 0) || ((a / 4) >= DEPTH);
   endfunction

   // Word-level view of a load: byte i lands in word i/4, big-endian
   task automatic modelLoad(input int n, input bit last, output int exp_words, output bit exp_err);
      int nw;
      nw = last ? (n + 3) / 4 : n / 4;
      for (int w = 0; w < nw && w < DEPTH; w++) begin
         logic [31:0] word;
         word = 32'h0;
         for (int k = 0; k < 4; k++) begin
            if (w * 4 + k < n) word = word | (32'(lb[w * 4 + k]) << (24 - 8 * k));
         end
         model_mem[w] = word;
         known[w]     = 1'b1;
      end
      exp_words = (nw < DEPTH) ? nw : DEPTH;
      exp_err   = (n > 4 * DEPTH);
   endtask

   task automatic doLoad(input int n, input bit with_last, input int max_gap);
      int  exp_words;
      bit  exp_err;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      checkOutput("load_ready_after_start", load_ready, 1);
      checkOutput("fetch_ready_in_load", fetch_ready, 0);
      checkOutput("load_words_cleared", load_words, 0);
      checkOutput("load_err_cleared", load_err, 0);
      for (int i = 0; i < n; i++) begin
         int g;
         g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
         load_valid = 1'b0;
         load_last  = 1'b0;
         repeat (g) step();
         load_valid = 1'b1;
         load_byte  = lb[i];
         load_last  = with_last && (i == n - 1);
         step();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      modelLoad(n, with_last, exp_words, exp_err);
      if (with_last) begin
         checkOutput("load_done_pulse", load_done, 1);
         checkOutput("load_words", load_words, exp_words);
         checkOutput("load_err", load_err, exp_err);
         checkOutput("fetch_ready_run", fetch_ready, 1);
         checkOutput("load_ready_run", load_ready, 0);
         step();
         checkOutput("load_done_single", load_done, 0);
      end
   endtask

   task automatic checkFetch(input logic [31:0] addr);
      logic f;
      int   w;
      f = expFault(addr);
      applyStimulus(1'b1, addr);
      checkOutput("fetch_valid", fetch_valid, 1);
      checkOutput("fetch_fault", fetch_fault, f);
      if (f) begin
         checkOutput("fetch_data_nop", fetch_data, 32'h0);
      end else begin
         w = addr / 4;
         if (known[w]) checkOutput("fetch_data", fetch_data, model_mem[w]);
      end
   endtask

   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rst        = 1'b1;
      load_start = 1'b0;
      load_byte  = 8'h00;
      load_valid = 1'b0;
      load_last  = 1'b0;
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      for (int k = 0; k < DEPTH; k++) known[k] = 1'b0;

      #2;
      checkOutput("rst_load_ready", load_ready, 0);
      checkOutput("rst_load_done", load_done, 0);
      checkOutput("rst_load_err", load_err, 0);
      checkOutput("rst_load_words", load_words, 0);
      checkOutput("rst_fetch_ready", fetch_ready, 0);
      checkOutput("rst_fetch_valid", fetch_valid, 0);
      checkOutput("rst_fetch_fault", fetch_fault, 0);
      checkOutput("rst_fetch_data", fetch_data, 32'h0);
      step();
      step();
      rst = 1'b0;
      step();
      checkOutput("idle_fetch_ready", fetch_ready, 0);
      checkOutput("idle_fetch_valid", fetch_valid, 0);
      step();
      checkOutput("idle_fetch_valid2", fetch_valid, 0);
      checkOutput("idle_load_ready", load_ready, 0);
      fetch_req = 1'b0;

      $display("[TB] two-word program load");
      lb[0] = 8'h3C; lb[1] = 8'h08; lb[2] = 8'h12; lb[3] = 8'h34;
      lb[4] = 8'h8D; lb[5] = 8'h09; lb[6] = 8'h00; lb[7] = 8'h04;
      doLoad(8, 1'b1, 0);

      vecs[0] = '{32'h0000_0000, 32'h3C08_1234, 1'b0};
      vecs[1] = '{32'h0000_0004, 32'h8D09_0004, 1'b0};
      vecs[2] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
      vecs[3] = '{32'h0000_0010, 32'h0000_0000, 1'b1};
      vecs[4] = '{32'h0000_0001, 32'h0000_0000, 1'b1};
      vecs[5] = '{32'h8000_0000, 32'h0000_0000, 1'b1};
      vecs[6] = '{32'h0000_0007, 32'h0000_0000, 1'b1};
      vecs[7] = '{32'h0000_0000, 32'h3C08_1234, 1'b0};
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, vecs[i].addr);
         checkOutput("vec_valid", fetch_valid, 1);
         checkOutput("vec_fault", fetch_fault, vecs[i].exp_fault);
         checkOutput("vec_data", fetch_data, vecs[i].exp_data);
      end
      applyStimulus(1'b0, 32'h4);
      checkOutput("idle_valid_low", fetch_valid, 0);
      checkOutput("idle_data_hold", fetch_data, 32'h3C08_1234);

      $display("[TB] partial-word padding");
      lb[0] = 8'hAA; lb[1] = 8'hBB; lb[2] = 8'hCC; lb[3] = 8'hDD; lb[4] = 8'hEE;
      doLoad(5, 1'b1, 0);
      checkFetch(32'h4);
      checkFetch(32'h0);
      fetch_req = 1'b0;

      $display("[TB] load_start beats a same-cycle byte");
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_byte  = 8'h11 * (i + 1);
         step();
      end
      load_valid = 1'b1;
      load_byte  = 8'h44;
      lb[0] = 8'h55; lb[1] = 8'h66; lb[2] = 8'h77; lb[3] = 8'h88;
      doLoad(4, 1'b1, 0);
      checkFetch(32'h0);
      checkFetch(32'h4);
      fetch_req = 1'b0;

      $display("[TB] fetch in the cycle RUN is left");
      fetch_req  = 1'b1;
      fetch_addr = 32'h4;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      fetch_req  = 1'b0;
      checkOutput("leave_run_valid", fetch_valid, 1);
      checkOutput("leave_run_data", fetch_data, 32'hEE00_0000);
      checkOutput("leave_run_fetch_ready", fetch_ready, 0);
      checkOutput("leave_run_load_ready", load_ready, 1);

      $display("[TB] overflow load");
      for (int i = 0; i < 20; i++) lb[i] = 8'($urandom);
      doLoad(20, 1'b1, 1);
      for (int w = 0; w < DEPTH; w++) checkFetch(32'(w * 4));
      fetch_req  = 1'b0;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      checkOutput("overflow_err_cleared", load_err, 0);

      $display("[TB] async reset mid-load");
      for (int i = 0; i < 9; i++) lb[i] = 8'($urandom);
      doLoad(9, 1'b0, 0);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_load_ready", load_ready, 0);
      checkOutput("async_rst_load_words", load_words, 0);
      checkOutput("async_rst_fetch_ready", fetch_ready, 0);
      step();
      rst = 1'b0;
      applyStimulus(1'b1, 32'h4);
      checkOutput("post_rst_blocked", fetch_valid, 0);
      fetch_req = 1'b0;
      lb[0] = 8'hDE; lb[1] = 8'hAD; lb[2] = 8'hBE; lb[3] = 8'hEF;
      doLoad(4, 1'b1, 0);
      checkFetch(32'h0);
      checkFetch(32'h4);
      checkFetch(32'h8);
      fetch_req = 1'b0;

      $display("[TB] randomized loads and fetches");
      for (int it = 0; it < 12; it++) begin
         int n;
         n = $urandom_range(1, 22);
         for (int i = 0; i < n; i++) lb[i] = 8'($urandom);
         fetch_req = 1'b0;
         doLoad(n, 1'b1, 2);
         for (int j = 0; j < 6; j++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 4 * DEPTH + 7));
            if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
            checkFetch(a);
         end
      end
      fetch_req = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
